// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared state encoding, opcode constants and width defaults for the ALU share controller
package alu_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_OP_W   = 3;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        gnt[gnt_idx] = any;
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one ALU among NUM_REQ requesters with round-robin grant,
// one-cycle start, timeout-guarded wait and a result pulse back to the winner only.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_op,
    output logic                      alu_start,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state, state_n;
    logic [IW-1:0]   ptr, owner, gnt_idx;
    logic [TW-1:0]   timer;
    logic [NUM_REQ-1:0] gnt;
    logic            any;
    logic            expired;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // timer counts completed WAIT cycles, so TIMEOUT-1 marks the last one
    assign expired = (timer == TW'(TIMEOUT - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = any ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = (alu_done || expired) ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            timer     <= '0;
            ack       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_start <= 1'b0;
        end else begin
            state     <= state_n;
            busy      <= (state_n != IDLE);
            ack       <= '0;
            alu_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: if (any) begin
                    alu_a     <= req_a[gnt_idx*DATA_W +: DATA_W];
                    alu_b     <= req_b[gnt_idx*DATA_W +: DATA_W];
                    alu_op    <= req_op[gnt_idx*OP_W +: OP_W];
                    owner     <= gnt_idx;
                    ack       <= gnt;
                    alu_start <= 1'b1;
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (alu_done) begin
                        rsp_data  <= alu_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << owner;
                    end else if (expired) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << owner;
                        timer     <= TW'(TIMEOUT);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    rsp_err <= 1'b0;
                    ptr     <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of arbitration order, latency, timeout, reset abort and spurious done
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    localparam int N = 4;
    localparam int DW = 16;
    localparam int OW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N*OW-1:0] req_op = '0;
    logic [N-1:0]    ack, rsp_valid;
    logic [DW-1:0]   rsp_data, alu_a, alu_b, alu_out;
    logic            rsp_err, busy, alu_start, alu_done;
    logic [OW-1:0]   alu_op;

    logic            alu_en = 1'b1;
    logic            spur = 1'b0;
    logic            done_q = 1'b0;
    logic [DW-1:0]   out_q = '0;
    int              starts = 0;
    int              cyc = 0;
    int              total = 0;
    int              bad = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_out   (alu_out),
        .alu_done  (alu_done)
    );

    // external one-cycle ALU stand-in; alu_en=0 models a hung ALU
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        done_q <= alu_start & alu_en;
        out_q  <= (alu_op == OP_SUB) ? alu_a - alu_b : alu_a + alu_b;
        if (alu_start) starts <= starts + 1;
    end
    assign alu_done = done_q | spur;
    assign alu_out  = out_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [OW-1:0] op, input logic [DW-1:0] exp_data,
                          input logic exp_err, input int exp_lat);
        int n, m, s0;
        s0 = starts;
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_op[i*OW +: OW] = op;
        req[i] = 1'b1;
        n = 0;
        while (ack == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack", 32'(ack), 32'(1 << i));
        chk("start", 32'(alu_start), 32'd1);
        chk("busy_op", 32'(busy), 32'd1);
        req[i] = 1'b0;
        m = 0;
        while (rsp_valid == '0 && m < 40) begin
            @(negedge clk);
            m++;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << i));
        chk("rsp_data", 32'(rsp_data), 32'(exp_data));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("latency", 32'(m), 32'(exp_lat));
        chk("starts", 32'(starts - s0), 32'd1);
        @(negedge clk);
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] exp3 [4];
        int n, last, seen;
        exp3 = '{16'd1, 16'd12, 16'd23, 16'd34};

        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(alu_start), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 100 - (-30)
        run_op(0, 16'd100, 16'hffe2, 3'b001, 16'd130, 1'b0, 2);
        // 32767 + 1 wraps
        run_op(2, 16'h7fff, 16'd1, 3'b000, 16'h8000, 1'b0, 2);

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = DW'(i * 10 + 1);
            req_b[i*DW +: DW] = DW'(i);
            req_op[i*OW +: OW] = OP_ADD;
        end
        req = 4'hf;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (ack == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rr_ack", 32'(ack), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_spacing", 32'(cyc - last), 32'd4);
            last = cyc;
            if (k == 4) req = '0;
            n = 0;
            while (rsp_valid == '0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("rr_rsp", 32'(rsp_valid), 32'(1 << (k % 4)));
            chk("rr_data", 32'(rsp_data), 32'(exp3[k % 4]));
        end
        repeat (2) @(negedge clk);

        alu_en = 1'b0;
        run_op(1, 16'd5, 16'd6, OP_ADD, 16'd0, 1'b1, 16);
        alu_en = 1'b1;
        run_op(3, 16'd7, 16'd8, OP_ADD, 16'd15, 1'b0, 2);

        alu_en = 1'b0;
        req_a[1*DW +: DW] = 16'd9;
        req_b[1*DW +: DW] = 16'd9;
        req_op[1*OW +: OW] = OP_ADD;
        req[1] = 1'b1;
        n = 0;
        while (ack == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_ack", 32'(ack), 32'd2);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp", 32'(rsp_valid), 32'd0);
        chk("abort_alu", {alu_a, alu_b}, 32'd0);
        chk("abort_misc", {ack, alu_op, alu_start, rsp_err}, 32'd0);
        rst = 1'b1;
        alu_en = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen = seen | int'(rsp_valid) | int'(ack);
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        run_op(1, 16'd9, 16'd3, OP_SUB, 16'd6, 1'b0, 2);

        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen = seen | int'(rsp_valid) | (int'(busy) << 8);
        end
        chk("spurious", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
